// File: rtl/harmonic_phase_seq.sv
// Per-harmonic linear phase sequencer: forms step = wo*n0 (Q16.16), then walks
// phase_m = (m*step) mod 2*pi for m = 1..L through an external modulus stage.
module harmonic_phase_seq #(
    parameter int              N        = 32,
    parameter int              Q        = 16,
    parameter int              MAX_HARM = 80,
    parameter logic [N-1:0]    TWO_PI   = 32'h0006487E
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [N-1:0]  wo,
    input  logic [N-1:0]  n0,
    input  logic [6:0]    num_harm,
    output logic          fmod_start,
    output logic [N-1:0]  fmod_num1,
    output logic [N-1:0]  fmod_num2,
    input  logic          fmod_done,
    input  logic [N-1:0]  fmod_mod,
    output logic [N-1:0]  phase_out,
    output logic [6:0]    phase_idx,
    output logic          phase_valid,
    output logic          busy,
    output logic          done
);

    localparam logic [3:0] S_IDLE  = 4'd0;
    localparam logic [3:0] S_MUL   = 4'd1;
    localparam logic [3:0] S_SREQ  = 4'd2;
    localparam logic [3:0] S_SWAIT = 4'd3;
    localparam logic [3:0] S_ADD   = 4'd4;
    localparam logic [3:0] S_MREQ  = 4'd5;
    localparam logic [3:0] S_MWAIT = 4'd6;
    localparam logic [3:0] S_EMIT  = 4'd7;
    localparam logic [3:0] S_DONE  = 4'd8;

    localparam logic [6:0] MAX_L = 7'(MAX_HARM);

    logic [3:0]          r_state;
    logic [N-1:0]        r_wo;
    logic [N-1:0]        r_n0;
    logic [6:0]          r_len;
    logic [6:0]          r_m;
    logic [N-1:0]        r_step;
    logic [N-1:0]        r_step_w;
    logic [N-1:0]        r_acc;
    logic [N-1:0]        r_sum;
    logic [N-1:0]        r_mod;
    logic                r_fmod_start;
    logic [N-1:0]        r_fmod_num1;
    logic [N-1:0]        r_phase_out;
    logic [6:0]          r_phase_idx;
    logic                r_phase_valid;
    logic                r_busy;
    logic                r_done;

    logic signed [2*N-1:0] w_prod;
    logic [N-1:0]          w_step;
    logic [6:0]            w_len;

    // Truncating Q16.16 multiply: keep product bits [Q+N-1:Q], no rounding.
    assign w_prod = $signed(r_wo) * $signed(r_n0);
    assign w_step = N'(w_prod >>> Q);
    assign w_len  = (num_harm > MAX_L) ? MAX_L : num_harm;

    assign fmod_num2   = TWO_PI;
    assign fmod_start  = r_fmod_start;
    assign fmod_num1   = r_fmod_num1;
    assign phase_out   = r_phase_out;
    assign phase_idx   = r_phase_idx;
    assign phase_valid = r_phase_valid;
    assign busy        = r_busy;
    assign done        = r_done;

    // NOTE: every state register uses <= so all updates in a cycle see the
    // pre-edge values; a blocking = here would create order-dependent logic.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= S_IDLE;
            r_wo          <= '0;
            r_n0          <= '0;
            r_len         <= '0;
            r_m           <= '0;
            r_step        <= '0;
            r_step_w      <= '0;
            r_acc         <= '0;
            r_sum         <= '0;
            r_mod         <= '0;
            r_fmod_start  <= 1'b0;
            r_fmod_num1   <= '0;
            r_phase_out   <= '0;
            r_phase_idx   <= '0;
            r_phase_valid <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_fmod_start  <= 1'b0;
            r_phase_valid <= 1'b0;
            r_done        <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_wo    <= wo;
                        r_n0    <= n0;
                        r_len   <= w_len;
                        r_state <= S_MUL;
                    end
                end
                S_MUL: begin
                    r_busy  <= 1'b1;
                    r_step  <= w_step[N-1] ? '0 : w_step;
                    r_state <= (r_len == 7'd0) ? S_DONE : S_SREQ;
                end
                S_SREQ: begin
                    r_fmod_num1  <= r_step;
                    r_fmod_start <= 1'b1;
                    r_state      <= S_SWAIT;
                end
                S_SWAIT: begin
                    if (fmod_done) begin
                        r_step_w <= fmod_mod;
                        r_acc    <= '0;
                        r_m      <= 7'd1;
                        r_state  <= S_ADD;
                    end
                end
                S_ADD: begin
                    // Both operands are already wrapped below 2*pi, so N bits suffice.
                    r_sum   <= r_acc + r_step_w;
                    r_state <= S_MREQ;
                end
                S_MREQ: begin
                    r_fmod_num1  <= r_sum;
                    r_fmod_start <= 1'b1;
                    r_state      <= S_MWAIT;
                end
                S_MWAIT: begin
                    if (fmod_done) begin
                        r_mod   <= fmod_mod;
                        r_state <= S_EMIT;
                    end
                end
                S_EMIT: begin
                    r_phase_out   <= r_mod;
                    r_phase_idx   <= r_m;
                    r_phase_valid <= 1'b1;
                    r_acc         <= r_mod;
                    if (r_m == r_len) begin
                        r_state <= S_DONE;
                    end else begin
                        r_m     <= r_m + 7'd1;
                        r_state <= S_ADD;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_harmonic_phase_seq.sv
// Bench for harmonic_phase_seq: behavioural modulus stage with latency mod_d,
// an output monitor, and an arithmetic reference model of the phase sequence.
module tb_harmonic_phase_seq;

    localparam logic [31:0] TWO_PI = 32'h0006487E;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [31:0] wo = '0;
    logic [31:0] n0 = '0;
    logic [6:0]  num_harm = '0;
    logic        mdl_done = 1'b0;
    logic        inj_done = 1'b0;
    logic [31:0] mdl_mod = '0;
    logic [31:0] inj_mod = '0;
    logic        fmod_done;
    logic [31:0] fmod_mod;
    logic        fmod_start;
    logic [31:0] fmod_num1;
    logic [31:0] fmod_num2;
    logic [31:0] phase_out;
    logic [6:0]  phase_idx;
    logic        phase_valid;
    logic        busy;
    logic        done;

    assign fmod_done = mdl_done | inj_done;
    assign fmod_mod  = inj_done ? inj_mod : mdl_mod;

    harmonic_phase_seq dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .wo          (wo),
        .n0          (n0),
        .num_harm    (num_harm),
        .fmod_start  (fmod_start),
        .fmod_num1   (fmod_num1),
        .fmod_num2   (fmod_num2),
        .fmod_done   (fmod_done),
        .fmod_mod    (fmod_mod),
        .phase_out   (phase_out),
        .phase_idx   (phase_idx),
        .phase_valid (phase_valid),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;
    int mod_d  = 3;

    // Monitor state, cleared at the start of each run.
    int          n_req, n_done, stab_err, pulse_err, num2_err;
    int          busy_rise_cyc, first_req_cyc, done_cyc;
    logic [31:0] first_req_num1;
    logic        done_busy;
    logic        prev_start, prev_busy;
    int          v_cyc[$];
    logic [31:0] v_ph[$];
    logic [6:0]  v_idx[$];
    logic [31:0] exp_q[$];

    task automatic clear_monitor();
        n_req = 0; n_done = 0; stab_err = 0; pulse_err = 0;
        busy_rise_cyc = -1; first_req_cyc = -1; done_cyc = -1;
        first_req_num1 = '0; done_busy = 1'b0;
        v_cyc.delete(); v_ph.delete(); v_idx.delete();
    endtask

    initial begin
        num2_err = 0; prev_start = 1'b0; prev_busy = 1'b0;
        clear_monitor();
        forever begin
            @(negedge clk);
            if (fmod_num2 !== TWO_PI) num2_err++;
            if (fmod_start === 1'b1) begin
                n_req++;
                if (prev_start === 1'b1) pulse_err++;
                if (first_req_cyc < 0) begin
                    first_req_cyc  = cyc;
                    first_req_num1 = fmod_num1;
                end
            end
            if (busy === 1'b1 && prev_busy !== 1'b1 && busy_rise_cyc < 0) busy_rise_cyc = cyc;
            if (phase_valid === 1'b1) begin
                v_cyc.push_back(cyc);
                v_ph.push_back(phase_out);
                v_idx.push_back(phase_idx);
            end
            if (done === 1'b1) begin
                n_done++;
                done_cyc  = cyc;
                done_busy = busy;
            end
            prev_start = fmod_start;
            prev_busy  = busy;
        end
    end

    // Behavioural modulus stage: answers each request mod_d cycles later and
    // watches that the dividend stays put until the answer is delivered.
    logic [31:0] m_held;
    bit          m_dead;
    initial begin
        forever begin
            @(negedge clk);
            if (fmod_start === 1'b1 && rst === 1'b1) begin
                m_held = fmod_num1;
                m_dead = 1'b0;
                for (int k = 0; k < mod_d; k++) begin
                    @(negedge clk);
                    if (rst !== 1'b1) m_dead = 1'b1;
                    if (!m_dead && fmod_num1 !== m_held) stab_err++;
                end
                mdl_mod = m_held;
                while (mdl_mod >= TWO_PI) mdl_mod = mdl_mod - TWO_PI;
                mdl_done = 1'b1;
                @(negedge clk);
                mdl_done = 1'b0;
            end
        end
    end

    // Reference: phase_m = (m * (step mod 2pi)) mod 2pi, step = trunc(wo*n0 / 2^16).
    function automatic int build_model(input logic [31:0] w, input logic [31:0] n, input int nh);
        longint p, sw, acc;
        int     s, len;
        len = (nh > 80) ? 80 : nh;
        p   = longint'($signed(w)) * longint'($signed(n));
        s   = int'(p >>> 16);
        if (s < 0) s = 0;
        sw  = longint'(s) % longint'(TWO_PI);
        acc = 0;
        exp_q.delete();
        for (int m = 1; m <= len; m++) begin
            acc = (acc + sw) % longint'(TWO_PI);
            exp_q.push_back(32'(acc));
        end
        return len;
    endfunction

    function automatic int phase_mismatches();
        int bad = 0;
        if (v_ph.size() != exp_q.size()) bad++;
        for (int i = 0; i < v_ph.size() && i < exp_q.size(); i++)
            if (v_ph[i] !== exp_q[i] || v_idx[i] !== 7'(i + 1)) bad++;
        return bad;
    endfunction

    function automatic int spacing_errs(input int want);
        int bad = 0;
        for (int i = 1; i < v_cyc.size(); i++)
            if (v_cyc[i] - v_cyc[i-1] != want) bad++;
        return bad;
    endfunction

    task automatic run_seq(input logic [31:0] w, input logic [31:0] n, input logic [6:0] nh,
                           output int start_edge, output bit timed_out);
        @(negedge clk);
        clear_monitor();
        wo = w; n0 = n; num_harm = nh; start = 1'b1;
        start_edge = cyc + 1;
        @(negedge clk);
        start = 1'b0;
        timed_out = 1'b1;
        for (int k = 0; k < 20000; k++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                timed_out = 1'b0;
                break;
            end
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({fmod_start, phase_valid, busy, done} !== 4'b0000)
            begin errors++; $display("FAIL reset_strobes: got %b, expected 0000", {fmod_start, phase_valid, busy, done}); end
        checks++;
        if (fmod_num1 !== 32'h0 || phase_out !== 32'h0 || phase_idx !== 7'h0)
            begin errors++; $display("FAIL reset_data: num1=%h phase=%h idx=%0d, expected all 0", fmod_num1, phase_out, phase_idx); end
        checks++;
        if (fmod_num2 !== TWO_PI)
            begin errors++; $display("FAIL reset_num2: got %h, expected %h", fmod_num2, TWO_PI); end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || fmod_start !== 1'b0)
            begin errors++; $display("FAIL post_reset_idle: busy=%b fmod_start=%b, expected 0 0", busy, fmod_start); end
    endtask

    task automatic test_basic();
        int se; bit to; int bad;
        mod_d = 3;
        exp_q = '{32'h0001921E, 32'h0003243C, 32'h0004B65A, 32'h00064878};
        run_seq(32'h0000C90F, 32'h00020000, 7'd4, se, to);
        checks++; if (to) begin errors++; $display("FAIL basic_timeout: done not seen, expected within bound"); end
        bad = phase_mismatches();
        checks++; if (bad != 0) begin errors++; $display("FAIL basic_phases: %0d mismatches of %0d, expected 0", bad, v_ph.size()); end
        checks++; if (n_req != 5) begin errors++; $display("FAIL basic_requests: got %0d, expected 5", n_req); end
        checks++; if (n_done != 1) begin errors++; $display("FAIL basic_done_count: got %0d, expected 1", n_done); end
        checks++; if (busy_rise_cyc != se + 1) begin errors++; $display("FAIL basic_busy_rise: got cycle %0d, expected %0d", busy_rise_cyc, se + 1); end
        checks++; if (first_req_cyc != se + 2) begin errors++; $display("FAIL basic_first_req: got cycle %0d, expected %0d", first_req_cyc, se + 2); end
        checks++; if (first_req_num1 !== 32'h0001921E) begin errors++; $display("FAIL basic_step: got %h, expected 0001921e", first_req_num1); end
        bad = spacing_errs(mod_d + 4);
        checks++; if (bad != 0) begin errors++; $display("FAIL basic_harm_spacing: %0d gaps off, expected 0 (gap %0d)", bad, mod_d + 4); end
        checks++; if (v_cyc.size() == 0 || done_cyc != v_cyc[$] + 1) begin errors++; $display("FAIL basic_done_after_valid: done at %0d, expected one past last valid", done_cyc); end
        checks++; if (done_busy !== 1'b0) begin errors++; $display("FAIL basic_busy_at_done: got %b, expected 0", done_busy); end
        checks++; if (pulse_err != 0 || stab_err != 0) begin errors++; $display("FAIL basic_handshake: pulse_err=%0d stab_err=%0d, expected 0 0", pulse_err, stab_err); end
    endtask

    task automatic test_step_wrap();
        int se; bit to; int bad;
        mod_d = 2;
        exp_q = '{32'h0001B782, 32'h00036F04};
        run_seq(32'h00010000, 32'h00080000, 7'd2, se, to);
        bad = phase_mismatches();
        checks++; if (to || bad != 0) begin errors++; $display("FAIL wrap_phases: timeout=%0d mismatches=%0d, expected 0 0", to, bad); end
        checks++; if (first_req_num1 !== 32'h00080000) begin errors++; $display("FAIL wrap_step: got %h, expected 00080000", first_req_num1); end
        checks++; if (n_req != 3) begin errors++; $display("FAIL wrap_requests: got %0d, expected 3", n_req); end
    endtask

    task automatic test_zero_len();
        int se; bit to;
        mod_d = 3;
        run_seq(32'h0000C90F, 32'h00020000, 7'd0, se, to);
        checks++; if (n_req != 0) begin errors++; $display("FAIL zero_requests: got %0d, expected 0", n_req); end
        checks++; if (v_ph.size() != 0) begin errors++; $display("FAIL zero_valid: got %0d strobes, expected 0", v_ph.size()); end
        checks++; if (to || n_done != 1 || done_cyc != se + 2) begin errors++; $display("FAIL zero_done: count=%0d cycle=%0d, expected 1 at %0d", n_done, done_cyc, se + 2); end
    endtask

    task automatic test_clamp();
        int se; bit to; int bad; int over;
        mod_d = 1;
        void'(build_model(32'h00008000, 32'h00010000, 100));
        run_seq(32'h00008000, 32'h00010000, 7'd100, se, to);
        checks++; if (to || v_ph.size() != 80) begin errors++; $display("FAIL clamp_count: got %0d strobes, expected 80", v_ph.size()); end
        bad = phase_mismatches();
        checks++; if (bad != 0) begin errors++; $display("FAIL clamp_phases_idx: %0d mismatches, expected 0", bad); end
        over = 0;
        foreach (v_ph[i]) if (v_ph[i] >= TWO_PI) over++;
        checks++; if (over != 0) begin errors++; $display("FAIL clamp_range: %0d phases >= 2pi, expected 0", over); end
        checks++; if (n_req != 81) begin errors++; $display("FAIL clamp_requests: got %0d, expected 81", n_req); end
    endtask

    task automatic test_stall();
        int se; bit to; int bad;
        mod_d = 20;
        void'(build_model(32'h0000C90F, 32'h00020000, 4));
        fork
            run_seq(32'h0000C90F, 32'h00020000, 7'd4, se, to);
            begin
                repeat (30) @(negedge clk);
                checks++; if (busy !== 1'b1) begin errors++; $display("FAIL stall_busy: got %b, expected 1", busy); end
                wo = 32'h00030000; start = 1'b1;
                @(negedge clk);
                start = 1'b0;
                for (int k = 0; k < 2000; k++) begin
                    @(negedge clk);
                    if (phase_valid === 1'b1) break;
                end
                inj_mod = 32'h00054321; inj_done = 1'b1;
                @(negedge clk);
                inj_done = 1'b0;
            end
        join
        bad = phase_mismatches();
        checks++; if (to || bad != 0) begin errors++; $display("FAIL stall_phases: timeout=%0d mismatches=%0d, expected 0 0", to, bad); end
        checks++; if (stab_err != 0) begin errors++; $display("FAIL stall_num1_stable: %0d changes, expected 0", stab_err); end
        checks++; if (n_done != 1 || n_req != 5) begin errors++; $display("FAIL stall_single_run: done=%0d req=%0d, expected 1 5", n_done, n_req); end
        bad = spacing_errs(mod_d + 4);
        checks++; if (bad != 0) begin errors++; $display("FAIL stall_spacing: %0d gaps off, expected 0", bad); end
    endtask

    task automatic test_reset_mid();
        int se; bit to; int seen; int bad;
        mod_d = 3;
        @(negedge clk);
        wo = 32'h0000C90F; n0 = 32'h00020000; num_harm = 7'd4; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seen = 0;
        for (int k = 0; k < 500; k++) begin
            @(negedge clk);
            if (fmod_start === 1'b1) seen++;
            if (seen == 3) break;
        end
        checks++; if (seen != 3) begin errors++; $display("FAIL rstmid_reach: saw %0d requests, expected 3", seen); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if ({fmod_start, phase_valid, busy, done} !== 4'b0000 || fmod_num1 !== 32'h0 ||
            phase_out !== 32'h0 || phase_idx !== 7'h0)
            begin errors++; $display("FAIL rstmid_outputs: busy=%b num1=%h phase=%h idx=%0d, expected all 0", busy, fmod_num1, phase_out, phase_idx); end
        clear_monitor();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (10) @(negedge clk);
        checks++;
        if (n_done != 0 || v_ph.size() != 0 || n_req != 0 || busy !== 1'b0)
            begin errors++; $display("FAIL rstmid_stray_done: done=%0d valid=%0d req=%0d busy=%b, expected 0 0 0 0", n_done, v_ph.size(), n_req, busy); end
        exp_q = '{32'h0001921E, 32'h0003243C, 32'h0004B65A, 32'h00064878};
        run_seq(32'h0000C90F, 32'h00020000, 7'd4, se, to);
        bad = phase_mismatches();
        checks++; if (to || bad != 0 || n_req != 5 || n_done != 1)
            begin errors++; $display("FAIL rstmid_rerun: mismatches=%0d req=%0d done=%0d, expected 0 5 1", bad, n_req, n_done); end
    endtask

    task automatic test_random();
        int se; bit to; int bad; int len;
        logic [31:0] w, n;
        logic [6:0]  nh;
        for (int r = 0; r < 10; r++) begin
            if (r == 0) begin
                w = 32'h7FFFFFFF; n = 32'h7FFFFFFF;
            end else begin
                w = $urandom_range(0, 32'h0006487E);
                n = $urandom_range(0, 32'h00A00000);
            end
            nh    = 7'($urandom_range(0, (r == 9) ? 127 : 24));
            mod_d = $urandom_range(1, 6);
            len   = build_model(w, n, int'(nh));
            run_seq(w, n, nh, se, to);
            bad = phase_mismatches();
            checks++; if (to || bad != 0)
                begin errors++; $display("FAIL rand%0d_phases: wo=%h n0=%h L=%0d mismatches=%0d, expected 0", r, w, n, len, bad); end
            checks++; if (n_req != ((len == 0) ? 0 : len + 1) || n_done != 1)
                begin errors++; $display("FAIL rand%0d_counts: req=%0d done=%0d, expected %0d 1", r, n_req, n_done, (len == 0) ? 0 : len + 1); end
        end
        checks++; if (num2_err != 0) begin errors++; $display("FAIL num2_constant: %0d deviations, expected 0", num2_err); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_step_wrap();
        test_zero_len();
        test_clamp();
        test_stall();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/harmonic_phase_seq.md
# harmonic_phase_seq

Sequencer that sits directly upstream of the fixed-point modulus stage in the 2400 bit/s encoder. It generates the per-harmonic linear phase term phase_m = (m·Wo·n0) mod 2π for m = 1..L. It computes one Q16.16 step, then accumulates it, issuing every intermediate value to the modulus block through its startfmod/donefmod handshake. Each wrapped phase is emitted with an index and a valid strobe.

## Interface
- N, 32: word width; all data ports are signed fixed point.
- Q, 16: fractional bits.
- MAX_HARM, 80: upper clamp for num_harm.
- TWO_PI, 32'h0006487E: modulus constant driven on fmod_num2.

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  begin a run; sampled only in IDLE.
- wo  in  N  fundamental in rad/sample, Q16.16, non-negative.
- n0  in  N  sample offset, Q16.16, non-negative.
- num_harm  in  7  harmonic count L.
- fmod_start  out  1  request to the modulus stage.
- fmod_num1  out  N  dividend.
- fmod_num2  out  N  divisor, always TWO_PI.
- fmod_done  in  1  modulus-stage completion pulse.
- fmod_mod  in  N  modulus result; valid while fmod_done=1.
- phase_out  out  N  wrapped phase for harmonic phase_idx.
- phase_idx  out  7  harmonic index 1..L.
- phase_valid  out  1  one-cycle strobe with phase_out/phase_idx.
- busy  out  1  high from start acceptance until done.
- done  out  1  one-cycle end-of-run strobe.

## Operation
The run proceeds through these states:

- **IDLE:** If start=1, latch wo, n0, and L = min(num_harm, MAX_HARM), then go to MUL. busy rises the next cycle.
- **MUL:** step = bits [47:16] of the 64-bit signed product wo·n0, truncated with no rounding. If the step is negative, force it to 0. Then:
  - L = 0 → DONE.
  - Otherwise → SREQ.
- **SREQ:** fmod_num1 = step, fmod_start = 1 for one cycle, then go to SWAIT.
- **SWAIT:** Hold fmod_num1. On fmod_done: step_w = fmod_mod, acc = 0, m = 1, then go to ADD.
- **ADD:** sum = acc + step_w. This is plain N-bit addition; no overflow is possible because both operands are < 2π.
- **MREQ:** fmod_num1 = sum, fmod_start = 1 for one cycle, then go to MWAIT.
- **MWAIT:** Hold fmod_num1. On fmod_done, go to EMIT.
- **EMIT:**
  - Set phase_out = fmod_mod (captured in MWAIT), phase_idx = m, phase_valid = 1.
  - acc = phase_out.
  - If m == L → DONE; otherwise m = m+1 → ADD.
- **DONE:** done = 1 and busy = 0 for one cycle, then go to IDLE.

Additional rules:
- The divisor is always TWO_PI. fmod_num2 is driven as TWO_PI constantly, including during reset.
- fmod_start is a registered pulse of exactly one cycle per request. The next request is never issued before the previous fmod_done.
- fmod_num1 stays stable from the fmod_start cycle through the fmod_done cycle, because the modulus stage samples it a cycle after the request.
- fmod_done is ignored outside SWAIT and MWAIT.
- start is ignored while busy=1.
- Per run, the block issues exactly L+1 modulus requests, or 0 requests when L = 0.

## Timing
- Reset (rst=0, asynchronous):
  - State returns to IDLE.
  - fmod_start, fmod_num1, phase_out, phase_idx, phase_valid, busy, done are all 0.
  - Internal acc, m, step_w are cleared.
  - A reset mid-run aborts the run; a later stray fmod_done is ignored.
- start sampled at edge 0 → busy=1 after edge 1; first fmod_start is high after edge 2.
- For a modulus latency of D cycles (fmod_start to fmod_done), each harmonic costs D+4 cycles (ADD, MREQ, wait, EMIT).
- Harmonic m's phase_valid rises 1 cycle after the MWAIT cycle in which fmod_done is seen.
- done rises 1 cycle after the last phase_valid. For L = 0, done rises 2 cycles after start.
- phase_out and phase_idx hold their last values until the next EMIT; only phase_valid qualifies them.

## Test plan
Benches use a behavioural modulus model (repeated subtraction while x ≥ TWO_PI) with configurable D, and repeat with the real modulus stage attached.

- **Basic, wrap boundary:** wo=32'h0000C90F, n0=32'h00020000, L=4, D=3.
  - Required: step=32'h0001921E.
  - phase_out = 32'h0001921E, 32'h0003243C, 32'h0004B65A, 32'h00064878 for idx 1..4.
  - The last value stays below TWO_PI, so it is not wrapped.
  - Exactly 5 fmod_start pulses, then one done pulse.
- **Step larger than 2π:** wo=32'h00010000, n0=32'h00080000, L=2.
  - Required: step_w = 32'h0001B782.
  - phases = 32'h0001B782, 32'h00036F04.
- **L=0:** start with num_harm=0.
  - Required: no fmod_start and no phase_valid.
  - done is high for one cycle, 2 cycles after start.
- **Clamp and indexing:** num_harm=100, wo=32'h00008000, n0=32'h00010000.
  - Required: exactly 80 phase_valid strobes with phase_idx 1..80 in order.
  - Every phase_out < 32'h0006487E.
- **Handshake stall and busy:** D=20 with start pulsed again mid-run.
  - Required: fmod_num1 is constant through every wait.
  - The second start is ignored, with a single done.
  - An extra fmod_done injected in ADD has no effect.
- **Reset mid-operation:** rst=0 during MWAIT of harmonic 2.
  - Required: all outputs go to 0 immediately, and the state returns to IDLE.
  - The model's late fmod_done is ignored.
  - A new start after reset reproduces scenario 1 exactly.
